// File: rtl/gpu_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : gpu_bus_initiator
// Description : Initiator end of the GPU external bus. Decodes a command
//               stream into single or incrementing bursts with timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_bus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'h0000_0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic [29:0] bus_address,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_write_data,
    input  logic        bus_acknowledge,
    input  logic [31:0] bus_read_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_bad_op,
    input  logic        err_clear
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_wdata = 3'd2;
    localparam logic [2:0] c_st_wr    = 3'd3;
    localparam logic [2:0] c_st_rd    = 3'd4;
    localparam logic [2:0] c_st_rsp   = 3'd5;
    localparam logic [2:0] c_st_drain = 3'd6;

    localparam logic [1:0] c_op_write = 2'b01;
    localparam logic [1:0] c_op_read  = 2'b10;
    localparam logic [1:0] c_op_bad   = 2'b11;

    // The counter only has to reach TIMEOUT_CYCLES-1; expiry fires on that value.
    localparam int unsigned     c_tw     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tw-1:0] c_tlimit = c_tw'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_op_read;
    logic [3:0]      r_be;
    logic [7:0]      r_left;
    logic [29:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_read;
    logic            r_write;
    logic [c_tw-1:0] r_tcount;
    logic            r_err_timeout;
    logic            r_err_bad_op;

    logic            w_ready_state;
    logic            w_fire;
    logic            w_strobe;
    logic            w_ack;
    logic            w_expire;
    logic            w_last;
    logic [1:0]      w_hdr_op;
    logic            w_burst_hdr;

    assign w_ready_state = (r_state == c_st_idle) || (r_state == c_st_addr) ||
                           (r_state == c_st_wdata) || (r_state == c_st_drain);
    // Gated by reset so every output reads zero while reset is held.
    assign cmd_ready     = w_ready_state & ~reset_reset;
    assign w_fire        = cmd_valid & cmd_ready;
    assign w_strobe      = r_read | r_write;
    assign w_ack         = bus_acknowledge & w_strobe;
    assign w_expire      = (TIMEOUT_CYCLES != 0) && w_strobe && !bus_acknowledge &&
                           (r_tcount == c_tlimit);
    assign w_last        = (r_left == 8'd0);
    assign w_hdr_op      = cmd_data[31:30];
    assign w_burst_hdr   = (w_hdr_op == c_op_write) || (w_hdr_op == c_op_read);

    assign bus_address     = r_addr;
    assign bus_byte_enable = r_be;
    assign bus_read        = r_read;
    assign bus_write       = r_write;
    assign bus_write_data  = r_wdata;
    assign rsp_valid       = (r_state == c_st_rsp);
    assign rsp_data        = r_rdata;
    assign busy            = (r_state != c_st_idle);
    assign err_timeout     = r_err_timeout;
    assign err_bad_op      = r_err_bad_op;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_fire && w_burst_hdr) begin
                    w_state_nxt = c_st_addr;
                end
            end
            c_st_addr: begin
                if (w_fire) begin
                    w_state_nxt = r_op_read ? c_st_rd : c_st_wdata;
                end
            end
            c_st_wdata: begin
                if (w_fire) begin
                    w_state_nxt = c_st_wr;
                end
            end
            c_st_wr: begin
                if (w_ack) begin
                    w_state_nxt = w_last ? c_st_idle : c_st_wdata;
                end else if (w_expire) begin
                    w_state_nxt = w_last ? c_st_idle : c_st_drain;
                end
            end
            c_st_rd: begin
                if (w_ack || w_expire) begin
                    w_state_nxt = c_st_rsp;
                end
            end
            c_st_rsp: begin
                if (rsp_ready) begin
                    w_state_nxt = w_last ? c_st_idle : c_st_rd;
                end
            end
            c_st_drain: begin
                if (w_fire && (r_left == 8'd1)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Strobes rise one cycle after entering WR/RD; leaving those states always
    // coincides with the strobe dropping, which guarantees a low gap per beat.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_op_read <= 1'b0;
            r_be      <= 4'd0;
            r_left    <= 8'd0;
            r_addr    <= 30'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_tcount  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_fire && w_burst_hdr) begin
                        r_op_read <= (w_hdr_op == c_op_read);
                        r_be      <= cmd_data[29:26];
                        r_left    <= cmd_data[7:0];
                    end
                end
                c_st_addr: begin
                    if (w_fire) begin
                        r_addr <= cmd_data[29:0];
                    end
                end
                c_st_wdata: begin
                    if (w_fire) begin
                        r_wdata <= cmd_data;
                    end
                end
                c_st_wr: begin
                    if (!r_write) begin
                        r_write  <= 1'b1;
                        r_tcount <= '0;
                    end else if (w_ack) begin
                        r_write <= 1'b0;
                        r_addr  <= r_addr + 30'd4;
                        if (!w_last) begin
                            r_left <= r_left - 8'd1;
                        end
                    end else if (w_expire) begin
                        r_write <= 1'b0;
                    end else begin
                        r_tcount <= r_tcount + c_tw'(1);
                    end
                end
                c_st_rd: begin
                    if (!r_read) begin
                        r_read   <= 1'b1;
                        r_tcount <= '0;
                    end else if (w_ack) begin
                        r_read  <= 1'b0;
                        r_rdata <= bus_read_data;
                        r_addr  <= r_addr + 30'd4;
                    end else if (w_expire) begin
                        // Aborted read: report one TIMEOUT_DATA word and end the burst.
                        r_read  <= 1'b0;
                        r_rdata <= TIMEOUT_DATA;
                        r_left  <= 8'd0;
                    end else begin
                        r_tcount <= r_tcount + c_tw'(1);
                    end
                end
                c_st_rsp: begin
                    if (rsp_ready && !w_last) begin
                        r_left <= r_left - 8'd1;
                    end
                end
                c_st_drain: begin
                    if (w_fire) begin
                        r_left <= r_left - 8'd1;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a new error event outranks a simultaneous clear.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_err_timeout <= 1'b0;
            r_err_bad_op  <= 1'b0;
        end else begin
            if (w_expire) begin
                r_err_timeout <= 1'b1;
            end else if (err_clear) begin
                r_err_timeout <= 1'b0;
            end
            if ((r_state == c_st_idle) && w_fire && (w_hdr_op == c_op_bad)) begin
                r_err_bad_op <= 1'b1;
            end else if (err_clear) begin
                r_err_bad_op <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
